// File: rtl/key_pkg.sv
// key_pkg
// Shared definitions for the front-panel key debouncer: per-channel FSM
// state encoding, channel index assignments and the default debounce
// length. Used by key_debounce and key_debounce_ch.
package key_pkg;

    typedef enum logic {
        KDB_STABLE    = 1'b0,
        KDB_CANDIDATE = 1'b1
    } key_db_state_t;

    localparam int KEY_CH_SWITCH           = 0;
    localparam int KEY_CH_RESET            = 1;
    localparam int KEY_N_KEYS_DEF          = 2;
    localparam int KEY_DEBOUNCE_CYCLES_DEF = 50000;

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch
// One key channel: 2-flop synchronizer, polarity normalisation to
// pressed = 1, and a stable/candidate FSM with a run-length counter.
// A level change is accepted only after the normalised, synchronised pin
// has differed from the accepted level for DEBOUNCE_CYCLES+1 consecutive
// cycles.
//
// Ports:
//   in_clk      system clock
//   in_rst      asynchronous active-low reset
//   in_key_raw  raw pin level, asynchronous, may bounce
//   o_key       debounced level, 1 = pressed, registered
//
// State table:
//   state         | meaning
//   KDB_STABLE    | input agrees with accepted level, counter held at 0
//   KDB_CANDIDATE | input differs from accepted level, counting agreement
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEF,
    parameter int IN_ACTIVE_LOW   = 1
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_key_raw,
    output logic o_key
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Pin level when the key is released; the synchronizer resets to it so
    // a key held through reset is seen as a fresh press.
    localparam logic PIN_IDLE = (IN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_level;

    key_db_state_t    r_state;
    key_db_state_t    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_stable;
    logic             w_stable_nxt;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_sync1 <= PIN_IDLE;
            r_sync2 <= PIN_IDLE;
        end else begin
            r_sync1 <= in_key_raw;
            r_sync2 <= r_sync1;
        end
    end

    // XOR with the idle level maps "pressed" to 1 for either polarity.
    assign w_level = r_sync2 ^ PIN_IDLE;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state  <= KDB_STABLE;
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        case (r_state)
            KDB_STABLE: begin
                w_cnt_nxt = '0;
                if (w_level != r_stable) begin
                    w_state_nxt = KDB_CANDIDATE;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            KDB_CANDIDATE: begin
                if (w_level == r_stable) begin
                    w_state_nxt = KDB_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_stable_nxt = ~r_stable;
                    w_state_nxt  = KDB_STABLE;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = KDB_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_key = r_stable;

endmodule

// File: rtl/key_debounce.sv
// key_debounce
// Multi-channel synchronizer/debouncer for front-panel push-buttons.
// Channel KEY_CH_SWITCH (0) is the switch key, KEY_CH_RESET (1) the reset
// key. Each channel is an independent key_debounce_ch.
//
// Ports:
//   in_clk      system clock
//   in_rst      asynchronous active-low reset
//   in_key_raw  raw pin levels, one per key
//   o_key       debounced, synchronous, active-high levels
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS          = KEY_N_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEF,
    parameter int IN_ACTIVE_LOW   = 1
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [N_KEYS-1:0] in_key_raw,
    output logic [N_KEYS-1:0] o_key
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IN_ACTIVE_LOW   (IN_ACTIVE_LOW)
        ) u_ch (
            .in_clk     (in_clk),
            .in_rst     (in_rst),
            .in_key_raw (in_key_raw[g]),
            .o_key      (o_key[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

    localparam int N  = 2;
    localparam int D  = 8;
    localparam int AL = 1;

    logic         in_clk = 1'b0;
    logic         in_rst = 1'b0;
    logic [N-1:0] in_key_raw = 2'b01;
    logic [N-1:0] o_key;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] exp_q[$];

    key_debounce #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D),
        .IN_ACTIVE_LOW   (AL)
    ) dut (
        .in_clk     (in_clk),
        .in_rst     (in_rst),
        .in_key_raw (in_key_raw),
        .o_key      (o_key)
    );

    always #5 in_clk = ~in_clk;

    // Reference model: pin samples travel through a two-deep delay line;
    // the accepted level flips once the delayed sample has disagreed with it
    // on D+1 consecutive edges.
    initial begin
        bit           s1[N];
        bit           s2[N];
        bit           acc[N];
        int           run[N];
        logic [N-1:0] e;
        for (int c = 0; c < N; c++) begin
            s1[c] = 1'b0; s2[c] = 1'b0; acc[c] = 1'b0; run[c] = 0;
        end
        forever begin
            @(posedge in_clk);
            for (int c = 0; c < N; c++) begin
                if (!in_rst) begin
                    s1[c] = 1'b0; s2[c] = 1'b0; acc[c] = 1'b0; run[c] = 0;
                end else begin
                    if (s2[c] != acc[c]) begin
                        run[c] = run[c] + 1;
                        if (run[c] == D + 1) begin
                            acc[c] = ~acc[c];
                            run[c] = 0;
                        end
                    end else begin
                        run[c] = 0;
                    end
                    s2[c] = s1[c];
                    s1[c] = ~in_key_raw[c];
                end
                e[c] = acc[c];
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compare o_key with the scoreboard every cycle.
    initial begin
        logic [N-1:0] w;
        forever begin
            @(posedge in_clk);
            #1;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty: no expected value at t=%0t, o_key=%b", $time, o_key);
            end else begin
                w = exp_q.pop_front();
                if (o_key !== w) begin
                    bad++;
                    $display("FAIL sb_okey: got=%b want=%b t=%0t", o_key, w, $time);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h t=%0t", nm, got, want, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    initial begin
        int           hold[N];
        logic         seen;
        int           highs;

        // Reset values with arbitrary pins
        wait_neg(3);
        check("rst_okey", 32'(o_key), 32'h0);
        in_key_raw = 2'b11;
        wait_neg(1);
        in_rst = 1'b1;
        wait_neg(4);

        // Clean press on channel 0
        in_key_raw[0] = 1'b0;
        wait_neg(10);
        check("press_k9", 32'(o_key[0]), 32'h0);
        wait_neg(1);
        check("press_k10", 32'(o_key[0]), 32'h1);
        check("press_ch1", 32'(o_key[1]), 32'h0);

        // Asynchronous reset mid-cycle clears before the next edge
        @(posedge in_clk);
        #2 in_rst = 1'b0;
        #1 check("async_clr", 32'(o_key), 32'h0);
        @(negedge in_clk);
        in_key_raw = 2'b11;
        wait_neg(1);
        in_rst = 1'b1;
        wait_neg(3);

        // Bounce rejection
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            in_key_raw[0] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge in_clk);
            seen = seen | o_key[0];
        end
        in_key_raw[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge in_clk);
            seen = seen | o_key[0];
        end
        check("bounce", 32'(seen), 32'h0);

        // Glitch of exactly D sampled cycles is rejected
        seen = 1'b0;
        in_key_raw[0] = 1'b0;
        for (int i = 0; i < D; i++) begin
            @(negedge in_clk);
            seen = seen | o_key[0];
        end
        in_key_raw[0] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge in_clk);
            seen = seen | o_key[0];
        end
        check("glitch8", 32'(seen), 32'h0);

        // Glitch of D+1 cycles passes: rises at k+10, falls 10 edges after release
        highs = 0;
        in_key_raw[0] = 1'b0;
        for (int i = 0; i < D + 1; i++) begin
            @(negedge in_clk);
            highs += int'(o_key[0]);
        end
        in_key_raw[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge in_clk);
            highs += int'(o_key[0]);
        end
        check("glitch9_hi", 32'(o_key[0]), 32'h1);
        @(negedge in_clk);
        check("glitch9_fall", 32'(o_key[0]), 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge in_clk);
            highs += int'(o_key[0]);
        end
        check("glitch9_width", 32'(highs), 32'd9);

        // Simultaneous press, then release channel 1 only
        in_key_raw = 2'b00;
        wait_neg(10);
        check("both_k9", 32'(o_key), 32'h0);
        wait_neg(1);
        check("both_k10", 32'(o_key), 32'h3);
        in_key_raw[1] = 1'b1;
        wait_neg(10);
        check("rel1_k9", 32'(o_key), 32'h3);
        wait_neg(1);
        check("rel1_k10", 32'(o_key), 32'h1);

        // Reset at count 5, then key held through reset release
        in_key_raw = 2'b11;
        wait_neg(14);
        check("idle_before_mid", 32'(o_key), 32'h0);
        in_key_raw[0] = 1'b0;
        wait_neg(7);
        in_rst = 1'b0;
        #1 check("midcount_rst", 32'(o_key[0]), 32'h0);
        wait_neg(2);
        in_rst = 1'b1;
        wait_neg(10);
        check("held_k9", 32'(o_key[0]), 32'h0);
        wait_neg(1);
        check("held_k10", 32'(o_key[0]), 32'h1);

        // Randomized pin activity with occasional reset pulses
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge in_clk);
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    in_key_raw[c] = 1'($urandom_range(0, 1));
                    hold[c] = int'($urandom_range(1, 14));
                end else begin
                    hold[c] = hold[c] - 1;
                end
            end
            in_rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        end
        @(negedge in_clk);
        in_rst = 1'b1;
        in_key_raw = 2'b11;
        wait_neg(15);
        check("final_idle", 32'(o_key), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
